// File: rtl/cpu_defs.sv
// Shared definitions for the fetch path: next-PC select codes, reset/IM constants
// and the request bundle handed from pc_unit to the target calculator.
package cpu_defs;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  typedef struct packed {
    npc_sel_e    sel;
    logic        taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
  } npc_req_t;

  // Address of the last legal instruction word.
  function automatic logic [31:0] im_last(input logic [31:0] base, input int words);
    return base + (32'(words) << 2) - 32'd4;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC mux plus alignment/range check of the selected target.
module npc_calc
  import cpu_defs::npc_sel_e;
  import cpu_defs::npc_req_t;
  import cpu_defs::im_last;
  import cpu_defs::NPC_SEQ;
  import cpu_defs::NPC_BRANCH;
  import cpu_defs::NPC_JUMP;
  import cpu_defs::NPC_JR;
#(
  parameter logic [31:0] BASE  = 32'h0000_3000,
  parameter int          WORDS = 4096
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  npc_req_t    req,
  output logic [31:0] npc,
  output logic        bad
);

  localparam logic [31:0] LAST = im_last(BASE, WORDS);

  logic [31:0] br_off;
  logic        plus4_wrap;

  assign br_off = {{14{req.imm16[15]}}, req.imm16, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (req.sel)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = req.taken ? pc_plus4 + br_off : pc_plus4;
      NPC_JUMP:   npc = {pc_plus4[31:28], req.instr_index, 2'b00};
      NPC_JR:     npc = req.rs_data;
      default:    npc = pc_plus4;
    endcase
  end

  // A pc_plus4 that rolled past 2^32 is never a valid target, even if IM sits at 0.
  assign plus4_wrap = (pc_plus4 < pc) && (req.sel != NPC_JR);

  assign bad = (npc[1:0] != 2'b00) || (npc < BASE) || (npc > LAST) || plus4_wrap;

endmodule

// File: rtl/pc_unit.sv
// Program counter with stall hold, sticky target fault and retired-instruction counter.
module pc_unit
  import cpu_defs::npc_sel_e;
  import cpu_defs::npc_req_t;
#(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] IM_BASE  = cpu_defs::IM_BASE,
  parameter int          IM_WORDS = cpu_defs::IM_WORDS,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      pc_plus4,
  input  logic [1:0]       npc_sel,
  input  logic             branch_taken,
  input  logic [15:0]      imm16,
  input  logic [25:0]      instr_index,
  input  logic [31:0]      rs_data,
  input  logic             stall,
  input  logic             fault_clr,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic [31:0]      link_addr,
  output logic             fault,
  output logic [31:0]      fault_pc,
  output logic [CNT_W-1:0] retired
);

  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  npc_req_t         req;
  logic             bad;

  assign req = '{sel:         npc_sel_e'(npc_sel),
                 taken:       branch_taken,
                 imm16:       imm16,
                 instr_index: instr_index,
                 rs_data:     rs_data};

  npc_calc #(
    .BASE  (IM_BASE),
    .WORDS (IM_WORDS)
  ) u_npc_calc (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4),
    .req      (req),
    .npc      (npc),
    .bad      (bad)
  );

  // Clear takes precedence over everything and consumes the cycle without advancing.
  always_comb begin
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    retired_d  = retired_q;
    if (fault_clr) begin
      fault_d = 1'b0;
    end else if (fault_q || stall) begin
      fault_d = fault_q;
    end else if (bad) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end else begin
      pc_d      = npc;
      retired_d = retired_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      retired_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      retired_q  <= retired_d;
    end
  end

  assign pc        = pc_q;
  assign link_addr = pc_plus4;
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reference model of the PC rules checked every cycle,
// plus hand-computed expectations at key points.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc_plus4;
  logic [1:0]  npc_sel = 2'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic        stall = 1'b0;
  logic        fault_clr = 1'b0;
  logic [31:0] pc, npc, link_addr, fault_pc, retired;
  logic        fault;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'd0;
  logic        done = 1'b0;
  int          n_total = 0;
  int          n_bad = 0;

  // Model state
  logic [31:0] m_pc = 32'h3000;
  logic        m_fault = 1'b0;
  logic [31:0] m_fault_pc = 32'd0;
  logic [31:0] m_retired = 32'd0;

  always #5 clk = ~clk;

  assign pc_plus4 = ovr_en ? ovr_val : pc + 32'd4;

  pc_unit #(
    .RESET_PC (32'h0000_3000),
    .IM_BASE  (32'h0000_3000),
    .IM_WORDS (4096),
    .CNT_W    (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_plus4     (pc_plus4),
    .npc_sel      (npc_sel),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .instr_index  (instr_index),
    .rs_data      (rs_data),
    .stall        (stall),
    .fault_clr    (fault_clr),
    .pc           (pc),
    .npc          (npc),
    .link_addr    (link_addr),
    .fault        (fault),
    .fault_pc     (fault_pc),
    .retired      (retired)
  );

  function automatic logic [31:0] m_plus4();
    return ovr_en ? ovr_val : m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_npc();
    logic [31:0] p4;
    int          off;
    p4 = m_plus4();
    off = int'($signed(imm16)) * 4;
    case (npc_sel)
      2'd0: return p4;
      2'd1: return branch_taken ? p4 + 32'(off) : p4;
      2'd2: return (p4 & 32'hF000_0000) + 32'(instr_index) * 32'd4;
      default: return rs_data;
    endcase
  endfunction

  function automatic logic m_bad();
    logic [31:0] t;
    t = m_npc();
    return (t % 4 != 0) || (t < 32'h3000) || (t > 32'h6FFC);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc       <= 32'h3000;
      m_fault    <= 1'b0;
      m_fault_pc <= 32'd0;
      m_retired  <= 32'd0;
    end else if (fault_clr) begin
      m_fault <= 1'b0;
    end else if (m_fault || stall) begin
      m_fault <= m_fault;
    end else if (m_bad()) begin
      m_fault    <= 1'b1;
      m_fault_pc <= m_pc;
    end else begin
      m_pc      <= m_npc();
      m_retired <= m_retired + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("cmp_pc", pc, m_pc);
      chk("cmp_fault", {31'd0, fault}, {31'd0, m_fault});
      chk("cmp_fault_pc", fault_pc, m_fault_pc);
      chk("cmp_retired", retired, m_retired);
      chk("cmp_npc", npc, m_npc());
      chk("cmp_link", link_addr, m_plus4());
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic tk, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs);
    npc_sel = sel; branch_taken = tk; imm16 = imm; instr_index = idx; rs_data = rs;
  endtask

  task automatic clear_fault();
    fault_clr = 1'b1;
    edge_step();
    chk("clr_fault", {31'd0, fault}, 32'd0);
    fault_clr = 1'b0;
  endtask

  initial begin
    edge_step(); edge_step();
    chk("rst_pc", pc, 32'h3000);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    reset_n = 1'b1;

    repeat (3) edge_step();
    chk("seq3_pc", pc, 32'h300C);
    chk("seq3_retired", retired, 32'd3);
    edge_step();
    chk("seq4_pc", pc, 32'h3010);

    drive(2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0);
    #1 chk("br_taken_npc", npc, 32'h3004);
    branch_taken = 1'b0;
    #1 chk("br_not_npc", npc, 32'h3014);
    branch_taken = 1'b1;
    edge_step();
    chk("br_pc", pc, 32'h3004);
    chk("br_retired", retired, 32'd5);

    drive(2'd1, 1'b1, 16'h0004, 26'd0, 32'd0);
    edge_step();
    chk("br_fwd_pc", pc, 32'h3018);

    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3000);
    edge_step();
    chk("jr_pc", pc, 32'h3000);

    drive(2'd2, 1'b0, 16'd0, 26'h0000C10, 32'd0);
    #1 chk("jump_npc", npc, 32'h3040);
    chk("jal_link", link_addr, 32'h3004);
    edge_step();
    chk("jump_pc", pc, 32'h3040);
    chk("jump_retired", retired, 32'd8);

    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3000);
    edge_step();
    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3002);
    edge_step();
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h3000);
    chk("mis_pc", pc, 32'h3000);

    drive(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    repeat (5) edge_step();
    chk("halt_pc", pc, 32'h3000);
    chk("halt_retired", retired, 32'd9);
    clear_fault();
    chk("clr_pc_hold", pc, 32'h3000);
    edge_step();
    chk("resume_pc", pc, 32'h3004);
    chk("resume_retired", retired, 32'd10);

    stall = 1'b1;
    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'd0);
    repeat (4) edge_step();
    chk("stall_pc", pc, 32'h3004);
    chk("stall_fault", {31'd0, fault}, 32'd0);
    chk("stall_retired", retired, 32'd10);
    stall = 1'b0;
    edge_step();
    chk("range_fault", {31'd0, fault}, 32'd1);
    chk("range_fault_pc", fault_pc, 32'h3004);

    clear_fault();
    fault_clr = 1'b1;
    edge_step();
    chk("clr_wins", {31'd0, fault}, 32'd0);
    fault_clr = 1'b0;
    edge_step();
    chk("refault", {31'd0, fault}, 32'd1);
    drive(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    clear_fault();

    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h6FFC);
    edge_step();
    chk("top_legal_pc", pc, 32'h6FFC);
    drive(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    edge_step();
    chk("top_over_fault", {31'd0, fault}, 32'd1);
    chk("top_over_pc", fault_pc, 32'h6FFC);
    clear_fault();
    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h2FFC);
    edge_step();
    chk("below_fault", {31'd0, fault}, 32'd1);
    clear_fault();
    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3018);
    edge_step();
    chk("back_pc", pc, 32'h3018);

    ovr_en = 1'b1; ovr_val = 32'd0;
    drive(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    edge_step();
    chk("wrap_fault", {31'd0, fault}, 32'd1);
    chk("wrap_fault_pc", fault_pc, 32'h3018);
    clear_fault();
    ovr_en = 1'b0;

    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3020);
    edge_step();
    chk("pre_rst_pc", pc, 32'h3020);
    drive(2'd3, 1'b0, 16'd0, 26'd0, 32'h3021);
    edge_step();
    chk("pre_rst_fault", {31'd0, fault}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h3000);
    chk("arst_fault", {31'd0, fault}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    chk("arst_fault_pc", fault_pc, 32'd0);
    drive(2'd0, 1'b0, 16'd0, 26'd0, 32'd0);
    edge_step(); edge_step();
    reset_n = 1'b1;
    edge_step();
    chk("post_rst_pc", pc, 32'h3004);
    chk("post_rst_retired", retired, 32'd1);

    @(negedge clk);
    #1 done = 1'b1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
